// File: rtl/text_pkg.sv
// Shared glyph constants and types for the text line renderer.
package text_pkg;

  localparam int GLYPH_W    = 32;
  localparam int GLYPH_BITS = 5;

  localparam logic [4:0] BLANK_GLYPH = 5'd31;
  localparam logic [4:0] LAST_LETTER = 5'd25;

  localparam logic [23:0] KEY_COLOR_DEFAULT = 24'hFF00FF;

  typedef logic [4:0] glyph_idx_t;

  function automatic logic is_letter(
    input glyph_idx_t g
  );
    return g <= LAST_LETTER;
  endfunction

endpackage

// File: rtl/text_string_buf.sv
// Double-buffered character string: shadow write port,
// frame-start commit into the active copy, active slot read.
module text_string_buf
  import text_pkg::*;
#(
  parameter int MAX_CHARS = 16,
  localparam int AW = $clog2(MAX_CHARS)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          commit,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  glyph_idx_t    wr_char,
  input  logic [AW-1:0] rd_slot,
  output glyph_idx_t    rd_glyph
);

  glyph_idx_t char_sh  [MAX_CHARS];
  glyph_idx_t char_act [MAX_CHARS];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MAX_CHARS; i++)
        char_sh[i] <= BLANK_GLYPH;
    end else if (wr_en) begin
      char_sh[wr_addr] <= wr_char;
    end
  end

  // Commit samples the pre-write shadow when both coincide.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MAX_CHARS; i++)
        char_act[i] <= BLANK_GLYPH;
    end else if (commit) begin
      for (int i = 0; i < MAX_CHARS; i++)
        char_act[i] <= char_sh[i];
    end
  end

  assign rd_glyph = char_act[rd_slot];

endmodule

// File: rtl/text_line_renderer.sv
// Renders one committed text line over the beam; 2-cycle latency.
// Optional chroma keying via TEXT_CHROMA_KEY_EN.
module text_line_renderer
  import text_pkg::*;
#(
  parameter int          MAX_CHARS = 16,
  parameter logic [23:0] KEY_COLOR = KEY_COLOR_DEFAULT,
  localparam int AW = $clog2(MAX_CHARS)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_start,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [4:0]    wr_char,
  input  logic [5:0]    str_len,
  input  logic [9:0]    org_x,
  input  logic [9:0]    org_y,
  output logic [9:0]    rom_addr,
  output logic [4:0]    rom_sel,
  input  logic [23:0]   rom_data,
  output logic          text_on,
  output logic [23:0]   text_rgb
);

  localparam logic [5:0] MAX_LEN = 6'(MAX_CHARS);

  logic [5:0] len_sh, len_act, len_clamp;
  logic [9:0] ox_sh, oy_sh, ox_act, oy_act;

  logic signed [10:0] dx, dy;
  logic               in_box;
  glyph_idx_t         glyph;

  logic hit1, show;

  assign len_clamp =
    (str_len > MAX_LEN) ? MAX_LEN : str_len;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      len_sh <= '0;
      ox_sh  <= '0;
      oy_sh  <= '0;
    end else begin
      len_sh <= len_clamp;
      ox_sh  <= org_x;
      oy_sh  <= org_y;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      len_act <= '0;
      ox_act  <= '0;
      oy_act  <= '0;
    end else if (frame_start) begin
      len_act <= len_sh;
      ox_act  <= ox_sh;
      oy_act  <= oy_sh;
    end
  end

  text_string_buf #(
    .MAX_CHARS (MAX_CHARS)
  ) u_buf (
    .Clk      (Clk),
    .Reset    (Reset),
    .commit   (frame_start),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_char  (wr_char),
    .rd_slot  (dx[AW+4:5]),
    .rd_glyph (glyph)
  );

  assign dx = $signed({1'b0, DrawX})
            - $signed({1'b0, ox_act});
  assign dy = $signed({1'b0, DrawY})
            - $signed({1'b0, oy_act});

  // Sign bits reject left/above; no wrap.
  assign in_box = !dx[10] && !dy[10]
               && (dy[9:5] == 5'd0)
               && (dx[10:5] < len_act);

  assign rom_addr =
    in_box ? {dy[4:0], dx[4:0]} : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit1    <= 1'b0;
      rom_sel <= BLANK_GLYPH;
    end else begin
      hit1    <= in_box && is_letter(glyph);
      rom_sel <= in_box ? glyph : BLANK_GLYPH;
    end
  end

`ifdef TEXT_CHROMA_KEY_EN
  assign show = hit1 && (rom_data != KEY_COLOR);
`else
  logic unused_key;
  assign unused_key = ^KEY_COLOR;
  assign show = hit1;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      text_on  <= 1'b0;
      text_rgb <= '0;
    end else begin
      text_on  <= show;
      text_rgb <= show ? rom_data : '0;
    end
  end

endmodule

// File: tb/tb_text_line_renderer.sv
// Randomized + directed bench for text_line_renderer
// against a pixel-level reference model.
module tb_text_line_renderer;
  import text_pkg::*;

  localparam int MC = 16;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic [9:0]  DrawX, DrawY;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_char;
  logic [5:0]  str_len;
  logic [9:0]  org_x, org_y;
  logic [9:0]  rom_addr;
  logic [4:0]  rom_sel;
  logic [23:0] rom_data;
  logic        text_on;
  logic [23:0] text_rgb;

  always #5 Clk = ~Clk;

  text_line_renderer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_char     (wr_char),
    .str_len     (str_len),
    .org_x       (org_x),
    .org_y       (org_y),
    .rom_addr    (rom_addr),
    .rom_sel     (rom_sel),
    .rom_data    (rom_data),
    .text_on     (text_on),
    .text_rgb    (text_rgb)
  );

  function automatic logic [23:0] rom_fn(
    input logic [4:0] s,
    input logic [9:0] a
  );
    return {s, a, a[8:0] ^ 9'h15A};
  endfunction

  // Sprite memory: registered address, selected by rom_sel.
  logic [9:0] addr_q = '0;
  logic       force_q = 1'b0;
  logic       force_cur = 1'b0;
  always @(posedge Clk) begin
    addr_q  <= rom_addr;
    force_q <= force_cur;
  end
  assign rom_data =
    force_q ? KEY : rom_fn(rom_sel, addr_q);

  int checks = 0;
  int errors = 0;

  int m_sh  [MC];
  int m_act [MC];
  int m_len_sh, m_len_act;
  int m_ox_sh, m_oy_sh, m_ox_act, m_oy_act;

  bit          prev_v;
  bit          p_on;
  logic [23:0] p_rgb;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MC; i++) begin
      m_sh[i]  = 31;
      m_act[i] = 31;
    end
    m_len_sh = 0; m_len_act = 0;
    m_ox_sh = 0; m_oy_sh = 0;
    m_ox_act = 0; m_oy_act = 0;
    prev_v = 1'b1;
    p_on   = 1'b0;
    p_rgb  = '0;
  endtask

  task automatic step(
    input int x, input int y,
    input bit fs = 0, input bit we = 0,
    input int wa = 0, input int wc = 31,
    input bit kf = 0
  );
    int dx, dy, g, a;
    bit inb, hit, on;
    logic [23:0] rgb;
    @(negedge Clk);
    DrawX = x[9:0];
    DrawY = y[9:0];
    frame_start = fs;
    wr_en = we;
    wr_addr = wa[3:0];
    wr_char = wc[4:0];
    force_cur = kf;
    dx = x - m_ox_act;
    dy = y - m_oy_act;
    inb = dx >= 0 && dy >= 0 && dy < 32
       && (dx / 32) < m_len_act;
    g = inb ? m_act[dx / 32] : 31;
    a = inb ? (dy % 32) * 32 + dx % 32 : 0;
    hit = inb && g <= 25;
    on = hit;
`ifdef TEXT_CHROMA_KEY_EN
    if (kf) on = 1'b0;
`endif
    rgb = !on ? 24'h0
        : kf  ? KEY
        : rom_fn(g[4:0], a[9:0]);
    #1;
    chk("rom_addr", 32'(rom_addr), a);
    @(posedge Clk);
    if (fs) begin
      m_act = m_sh;
      m_len_act = m_len_sh;
      m_ox_act = m_ox_sh;
      m_oy_act = m_oy_sh;
    end
    if (we && wa < MC) m_sh[wa] = wc;
    m_len_sh = (str_len > MC) ? MC : int'(str_len);
    m_ox_sh = org_x;
    m_oy_sh = org_y;
    #1;
    chk("rom_sel", 32'(rom_sel), g);
    if (prev_v) begin
      chk("text_on", 32'(text_on), 32'(p_on));
      chk("text_rgb", 32'(text_rgb), 32'(p_rgb));
    end
    prev_v = 1'b1;
    p_on = on;
    p_rgb = rgb;
  endtask

  task automatic rnd_px(input int n);
    for (int i = 0; i < n; i++)
      step((m_ox_act + $urandom_range(0, 560) - 20) & 1023,
           (m_oy_act + $urandom_range(0, 40) - 4) & 1023);
  endtask

  initial begin
    Reset = 1'b1;
    frame_start = 0; wr_en = 0;
    wr_addr = 0; wr_char = 0;
    DrawX = 0; DrawY = 0;
    str_len = 0; org_x = 0; org_y = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_text_on", 32'(text_on), 0);
    chk("rst_rom_sel", 32'(rom_sel), 31);
    chk("rst_text_rgb", 32'(text_rgb), 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Reset state: nothing committed, sweep is blank.
    rnd_px(20);
    step(0, 0, 1);
    rnd_px(10);

    // "AB" at (100,50).
    str_len = 2; org_x = 100; org_y = 50;
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 1);
    step(133, 52);
    step(164, 50);
    step(99, 50);
    step(163, 81);
    step(100, 82);
    step(101, 51, 0, 0, 0, 31, 1);
    step(102, 51);

    // Write 'Z' together with commit.
    step(105, 55, 1, 1, 0, 25);
    step(105, 55);
    step(106, 56);
    step(0, 0, 1);
    step(105, 55);
    step(107, 57);

    // Length 0, clamp above MAX_CHARS, edge clip.
    str_len = 0;
    step(0, 0);
    step(0, 0, 1);
    step(105, 55);
    str_len = 40; org_x = 620; org_y = 470;
    for (int i = 0; i < MC; i++)
      step(0, 0, 0, 1, i, i);
    step(0, 0, 1);
    step(1023, 470);
    step(639, 479);
    step(620, 501);
    step(620, 502);
    rnd_px(20);

    // Randomized writes, commits, geometry.
    for (int k = 0; k < 40; k++) begin
      str_len = 6'($urandom_range(0, 40));
      org_x = 10'($urandom_range(0, 660));
      org_y = 10'($urandom_range(0, 490));
      for (int j = 0; j < 4; j++)
        step(0, 0, 0, 1, $urandom_range(0, MC - 1),
             $urandom_range(0, 31));
      step(0, 0, ($urandom_range(0, 3) != 0),
           1, $urandom_range(0, MC - 1),
           $urandom_range(0, 31));
      for (int j = 0; j < 15; j++)
        step((m_ox_act + $urandom_range(0, 560) - 20) & 1023,
             (m_oy_act + $urandom_range(0, 40) - 4) & 1023,
             0, 0, 0, 31, ($urandom_range(0, 9) == 0));
    end

    // Mid-line reset with text showing.
    str_len = 3; org_x = 200; org_y = 100;
    step(0, 0, 0, 1, 0, 7);
    step(0, 0, 0, 1, 1, 8);
    step(0, 0, 0, 1, 2, 9);
    step(0, 0, 1);
    step(210, 110);
    step(211, 111);
    chk("pre_rst_on", 32'(text_on), 1);
    #1 Reset = 1'b1;
    #1;
    chk("arst_text_on", 32'(text_on), 0);
    chk("arst_rom_sel", 32'(rom_sel), 31);
    chk("arst_text_rgb", 32'(text_rgb), 0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    rnd_px(10);
    step(0, 0, 1);
    step(210, 110);
    step(240, 120);
    step(0, 0, 0, 1, 0, 3);
    step(0, 0, 1);
    step(210, 110);
    step(211, 111);
    step(0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/text_line_renderer.md
# text_line_renderer

Renders one line of up to MAX_CHARS letter glyphs at a programmable screen origin. It sits directly upstream of the per-letter 32x32x24-bit glyph sprite memories. From the current beam coordinates it generates the shared 10-bit glyph read address and a glyph select. It then consumes the selected 24-bit sprite word one cycle later and emits an aligned pixel colour plus a text-hit flag to the colour mapper. String contents, length and origin are double-buffered and commit only at frame start, so a line never tears mid-frame.

## Interface
- MAX_CHARS, 16: character slots in the line; power of two, 2..32.
- KEY_COLOR, 24'hFF00FF: transparent sprite colour; used only with the configuration macro defined.

- Clk  in  1  system clock; all state on posedge
- Reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at vsync; commits shadow state
- DrawX  in  10  current beam column
- DrawY  in  10  current beam row
- wr_en  in  1  write one character into the shadow string
- wr_addr  in  $clog2(MAX_CHARS)  shadow slot to write
- wr_char  in  5  glyph index: 0..25 = A..Z; 26..31 = blank
- str_len  in  6  shadow line length; values above MAX_CHARS clamp to MAX_CHARS
- org_x  in  10  shadow origin column
- org_y  in  10  shadow origin row
- rom_addr  out  10  glyph read address {row[4:0], col[4:0]}, combinational from DrawX/DrawY
- rom_sel  out  5  registered glyph index aligned with the returned sprite word
- rom_data  in  24  selected sprite word, valid one cycle after rom_addr
- text_on  out  1  registered; pixel belongs to visible text
- text_rgb  out  24  registered colour; 0 when text_on = 0

## Operation
- Shadow state: char_sh[MAX_CHARS], len_sh, ox_sh, oy_sh.
  - wr_en writes char_sh[wr_addr].
  - len/origin shadows track their inputs every cycle.
- Active state: char_act, len_act, ox_act, oy_act.
  - All four are copied from shadow on frame_start and hold otherwise.
- Stage 0 (combinational, cycle t):
  - dx = {1'b0,DrawX} − {1'b0,ox_act} and dy = {1'b0,DrawY} − {1'b0,oy_act}, each 11-bit signed.
  - in_box = dx ≥ 0, dy ≥ 0, dy < 32, and dx[10:5] < len_act.
  - slot = dx[9:5]; glyph = char_act[slot].
  - rom_addr = {dy[4:0], dx[4:0]}. When in_box = 0, rom_addr = 0.
- Stage 1 (register at end of t):
  - hit1 = in_box && glyph ≤ 25.
  - rom_sel = glyph when in_box, else 31.
- Stage 2 (register at end of t+1):
  - text_on = hit1, gated by the configuration macro below.
  - text_rgb = rom_data when text_on, else 0.
- Boundaries:
  - len_act = 0 yields no hits.
  - The right edge is exclusive: dx = len_act*32 is outside.
  - No wrap: an origin near 639/479 clips; negative dx/dy are outside.
- Simultaneous events:
  - wr_en and frame_start in the same cycle: active takes the pre-write shadow; the written char appears at the following frame_start.
  - wr_addr ≥ MAX_CHARS is ignored.
- Reset:
  - char_sh and char_act fill with 31.
  - Lengths, origins, rom_sel (31), hit1, text_on and text_rgb clear to 0.
  - Reset mid-frame blanks the line immediately and recovers on the next frame_start after shadow writes.

## Timing
- Latency is 2 cycles from DrawX/DrawY to text_on/text_rgb.
- rom_addr is the only combinational output. The sprite memory registers it and returns rom_data during t+1, matching rom_sel.
- The pipeline runs every cycle. There is no stall and no valid handshake; the consumer delays its own DrawX/DrawY by 2.
- frame_start takes effect on pixels whose stage 0 falls in the cycle after the pulse.

## Configuration
- TEXT_CHROMA_KEY_EN
  - Defined: text_on = hit1 && (rom_data != KEY_COLOR), so keyed pixels show background.
  - Undefined: text_on = hit1, and the whole 32x32 glyph cell, including key-coloured pixels, is drawn.

## Structure
- Shared package text_pkg holds:
  - GLYPH_W = 32 and GLYPH_BITS = 5;
  - BLANK_GLYPH = 5'd31 and LAST_LETTER = 5'd25;
  - the typedef glyph_idx_t (logic [4:0]) and KEY_COLOR_DEFAULT.
- One natural sub-module, text_string_buf: the shadow/active character arrays with write port, commit and slot read.

## Test plan
- Reset, then sweep → text_on = 0 everywhere; rom_sel = 31; text_rgb = 0.
- Write "AB" to slots 0–1, str_len = 2, origin (100,50), pulse frame_start, drive (133,52) → rom_addr = {5'd2,5'd1}, rom_sel = 1 one cycle later, text_on = 1 and text_rgb = rom_data two cycles later.
- Same setup, drive (164,50) and (99,50) → text_on = 0 (right edge exclusive, left of origin).
- Write slot 0 = 'Z' in the same cycle as frame_start → old glyph stays this frame; 'Z' appears after the next frame_start.
- With TEXT_CHROMA_KEY_EN, force rom_data = 24'hFF00FF at a hit pixel → text_on = 0. Without the macro → text_on = 1 and text_rgb = 24'hFF00FF.
- Assert Reset mid-line while text_on = 1 → outputs clear asynchronously, and the line stays blank until rewritten and committed.
